// File: rtl/des_nibble_sequencer.sv
// des_nibble_sequencer: latches a 32-bit word, walks a 3-bit select across the
// external 8:1 nibble mux, and forwards each returned nibble downstream over a
// valid/ready handshake while rebuilding the word in word_out for loopback.
// Optional build macro NIBBLE_MSB_FIRST_EN: walk the select 7..0 instead of 0..7.
module des_nibble_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] word_in,
    output logic [31:0] mux_load,
    output logic [2:0]  mux_sel,
    input  logic [3:0]  mux_nib,
    output logic [3:0]  nib_out,
    output logic        nib_valid,
    input  logic        nib_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] word_out
);

`ifdef NIBBLE_MSB_FIRST_EN
    localparam logic [2:0] FIRST_SEL = 3'd7;
    localparam logic [2:0] LAST_SEL  = 3'd0;
    localparam logic [2:0] SEL_STEP  = 3'd7;  // -1 modulo 8
`else
    localparam logic [2:0] FIRST_SEL = 3'd0;
    localparam logic [2:0] LAST_SEL  = 3'd7;
    localparam logic [2:0] SEL_STEP  = 3'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic load;
    logic xfer;
    logic last;

    // Abort blocks both a new load and a same-cycle transfer.
    assign load = (state == S_IDLE) && start && !abort;
    assign xfer = (state == S_RUN) && nib_ready && !abort;
    assign last = (mux_sel == LAST_SEL);

    // Status flags decode straight from the state register, so they are glitch-free.
    assign busy      = (state == S_RUN);
    assign nib_valid = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign nib_out   = nib_valid ? mux_nib : 4'h0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE always falls back to IDLE after one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort)             state_nxt = S_IDLE;
                else if (xfer && last) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch word on load, capture each transferred nibble into its slot
    // and advance the select; the select parks on the final index (no wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_load <= 32'h0;
            mux_sel  <= FIRST_SEL;
            word_out <= 32'h0;
        end else if (load) begin
            mux_load <= word_in;
            mux_sel  <= FIRST_SEL;
            word_out <= 32'h0;
        end else if (xfer) begin
            word_out[{mux_sel, 2'b00} +: 4] <= mux_nib;
            if (!last) mux_sel <= mux_sel + SEL_STEP;
        end
    end

endmodule

// File: tb/tb_des_nibble_sequencer.sv
// Directed bench for des_nibble_sequencer. Inputs change and outputs are
// sampled on the falling edge; the 8:1 nibble mux is modelled locally.
module tb_des_nibble_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] word_in;
    logic [31:0] mux_load;
    logic [2:0]  mux_sel;
    logic [3:0]  mux_nib;
    logic [3:0]  nib_out;
    logic        nib_valid;
    logic        nib_ready;
    logic        busy;
    logic        done;
    logic [31:0] word_out;

    int n_tests = 0;
    int n_fail  = 0;

    des_nibble_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .word_in  (word_in),
        .mux_load (mux_load),
        .mux_sel  (mux_sel),
        .mux_nib  (mux_nib),
        .nib_out  (nib_out),
        .nib_valid(nib_valid),
        .nib_ready(nib_ready),
        .busy     (busy),
        .done     (done),
        .word_out (word_out)
    );

    // external 8:1 nibble mux
    assign mux_nib = mux_load[{mux_sel, 2'b00} +: 4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef NIBBLE_MSB_FIRST_EN
    localparam logic [2:0] RST_SEL = 3'd7;
`else
    localparam logic [2:0] RST_SEL = 3'd0;
`endif

    // select index used for the k-th nibble of a run
    function automatic logic [2:0] idx(input int k);
`ifdef NIBBLE_MSB_FIRST_EN
        return 3'(7 - k);
`else
        return 3'(k);
`endif
    endfunction

    function automatic logic [3:0] nib_of(input logic [31:0] w, input int k);
        logic [31:0] s;
        s = w >> (4 * int'(idx(k)));
        return s[3:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One run from the start cycle through the idle cycle that follows it.
    // stall_at/abort_at select the nibble index at which to act (-1 = never).
    task automatic run_word(input string tag, input logic [31:0] w, input int stall_at,
                            input int stall_cyc, input int abort_at, input bit hold_start);
        logic [31:0] exp_wo;
        exp_wo  = 32'h0;
        word_in = w;
        start   = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == abort_at) begin
                chk({tag, "_abort_valid"}, 32'(nib_valid), 32'd1);
                chk({tag, "_abort_nib"}, 32'(nib_out), 32'(nib_of(w, k)));
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
                chk({tag, "_abort_nvalid"}, 32'(nib_valid), 32'd0);
                chk({tag, "_abort_done"}, 32'(done), 32'd0);
                chk({tag, "_abort_wout"}, word_out, exp_wo);
                chk({tag, "_abort_load"}, mux_load, w);
                @(negedge clk);
                chk({tag, "_abort_done2"}, 32'(done), 32'd0);
                return;
            end
            if (k == stall_at) begin
                nib_ready = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    chk({tag, "_stall_valid"}, 32'(nib_valid), 32'd1);
                    chk({tag, "_stall_nib"}, 32'(nib_out), 32'(nib_of(w, k)));
                    chk({tag, "_stall_sel"}, 32'(mux_sel), 32'(idx(k)));
                    @(negedge clk);
                end
                nib_ready = 1'b1;
            end
            chk({tag, "_valid"}, 32'(nib_valid), 32'd1);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nib"}, 32'(nib_out), 32'(nib_of(w, k)));
            chk({tag, "_sel"}, 32'(mux_sel), 32'(idx(k)));
            chk({tag, "_early_done"}, 32'(done), 32'd0);
            if (hold_start) word_in = ~w ^ 32'(k);
            exp_wo[4 * int'(idx(k)) +: 4] = nib_of(w, k);
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_nvalid"}, 32'(nib_valid), 32'd0);
        chk({tag, "_done_nib"}, 32'(nib_out), 32'd0);
        chk({tag, "_wout"}, word_out, w);
        chk({tag, "_load"}, mux_load, w);
        if (hold_start) start = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        word_in   = 32'h0;
        nib_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_load", mux_load, 32'h0);
        chk("rst_sel", 32'(mux_sel), 32'(RST_SEL));
        chk("rst_nib", 32'(nib_out), 32'h0);
        chk("rst_valid", 32'(nib_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wout", word_out, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // default order F,E,D,C,B,A,9,8; macro order 8,9,A,...,F
        run_word("stream", 32'h89ABCDEF, -1, 0, -1, 1'b0);
        chk("stream_wout_const", word_out, 32'h89ABCDEF);

        // third nibble (6 at select 2 in the default build) held for 3 cycles
        run_word("bp", 32'h12345678, 2, 3, -1, 1'b0);

        // abort while the 5th nibble is valid: four nibbles captured
        run_word("abort", 32'h89ABCDEF, -1, 0, 4, 1'b0);
`ifdef NIBBLE_MSB_FIRST_EN
        chk("abort_wout_const", word_out, 32'h89AB0000);
`else
        chk("abort_wout_const", word_out, 32'h0000CDEF);
`endif
        run_word("post_abort", 32'hFFFFFFFF, -1, 0, -1, 1'b0);

        // start held and word_in wiggling during RUN must not disturb the run
        run_word("collide", 32'hA5C31E7D, -1, 0, -1, 1'b1);

        // start together with abort in IDLE stays idle
        start   = 1'b1;
        abort   = 1'b1;
        word_in = 32'h55555555;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_valid", 32'(nib_valid), 32'd0);
        chk("sa_load", mux_load, 32'hA5C31E7D);
        @(negedge clk);
        chk("sa_busy2", 32'(busy), 32'd0);

        // back-to-back: each run_word returns in the idle cycle N+10
        run_word("b2b_a", 32'h0F1E2D3C, -1, 0, -1, 1'b0);
        run_word("b2b_b", 32'h76543210, -1, 0, -1, 1'b0);

        // asynchronous reset between clock edges in the middle of a run
        word_in = 32'hDEADBEEF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_arst_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(nib_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sel", 32'(mux_sel), 32'(RST_SEL));
        chk("arst_wout", word_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_arst_done", 32'(done), 32'd0);
        chk("post_arst_busy", 32'(busy), 32'd0);

        run_word("post_arst", 32'h13579BDF, -1, 0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
